mant_div_seq: RTL and testbench

Iterative restoring mantissa divider for the single-precision IEEE 754 divide path. It takes two 24-bit significands with the hidden bit included and produces a 26-bit quotient: 1 integer bit, 23 fraction bits, guard and round. It also produces a sticky bit from the final remainder. It sits directly upstream of the normalise/round stage, and each iteration's trial subtraction runs on the team's 26-bit carry-lookahead adder.

---
 rtl/mant_div_seq.sv | 127 ++++++++++++
 tb/tb_mant_div_seq.sv | 159 +++++++++++++++
 2 files changed

// File: rtl/mant_div_seq.sv
// rtl/mant_div_seq.sv - iterative restoring significand divider, one quotient bit per cycle
module mant_div_seq #(
    parameter int MW = 24,
    parameter int QW = 26
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          start,
    input  logic [MW-1:0] a_man,
    input  logic [MW-1:0] b_man,
    output logic          busy,
    output logic          done,
    output logic [QW-1:0] quo,
    output logic          sticky,
    output logic          dz
);
    localparam int CW = $clog2(QW);

    typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

    state_t        state_q, state_d;
    logic [QW-1:0] rem_q, rem_d;
    logic [MW-1:0] div_q, div_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [QW-1:0] qsr_q, qsr_d;
    logic [QW-1:0] quo_q, quo_d;
    logic          sticky_q, sticky_d;
    logic          dz_q, dz_d;
    logic          busy_q, busy_d;
    logic          done_q, done_d;

    logic [QW-1:0] neg_div;
    logic [QW:0]   diff;
    logic          q_bit;

    // Trial subtraction as rem + (2^QW - div); the carry-out is the "rem >= div" decision.
    assign neg_div = ~{{(QW-MW){1'b0}}, div_q} + {{(QW-1){1'b0}}, 1'b1};
    assign diff    = {1'b0, rem_q} + {1'b0, neg_div};

    always_comb begin
        state_d  = state_q;
        rem_d    = rem_q;
        div_d    = div_q;
        cnt_d    = cnt_q;
        qsr_d    = qsr_q;
        quo_d    = quo_q;
        sticky_d = sticky_q;
        dz_d     = dz_q;
        busy_d   = busy_q;
        done_d   = 1'b0;
        q_bit    = 1'b0;
        case (state_q)
            IDLE: begin
                if (start) begin
                    div_d   = b_man;
                    rem_d   = {{(QW-MW){1'b0}}, a_man};
                    cnt_d   = '0;
                    qsr_d   = '0;
                    busy_d  = 1'b1;
                    state_d = CALC;
                end
            end
            CALC: begin
                if (div_q == '0) begin
                    // Divide-by-zero skips the iterations and reports a saturated quotient.
                    quo_d    = '1;
                    sticky_d = 1'b0;
                    dz_d     = 1'b1;
                    done_d   = 1'b1;
                    state_d  = DONE;
                end else begin
                    q_bit = diff[QW];
                    rem_d = q_bit ? {diff[QW-2:0], 1'b0} : {rem_q[QW-2:0], 1'b0};
                    qsr_d = {qsr_q[QW-2:0], q_bit};
                    cnt_d = cnt_q + CW'(1);
                    if (cnt_q == CW'(QW-1)) begin
                        quo_d    = qsr_d;
                        sticky_d = |rem_d;
                        dz_d     = 1'b0;
                        done_d   = 1'b1;
                        state_d  = DONE;
                    end
                end
            end
            DONE: begin
                busy_d  = 1'b0;
                state_d = IDLE;
            end
            default: begin
                busy_d  = 1'b0;
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= IDLE;
            rem_q    <= '0;
            div_q    <= '0;
            cnt_q    <= '0;
            qsr_q    <= '0;
            quo_q    <= '0;
            sticky_q <= 1'b0;
            dz_q     <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            rem_q    <= rem_d;
            div_q    <= div_d;
            cnt_q    <= cnt_d;
            qsr_q    <= qsr_d;
            quo_q    <= quo_d;
            sticky_q <= sticky_d;
            dz_q     <= dz_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
        end
    end

    assign busy   = busy_q;
    assign done   = done_q;
    assign quo    = quo_q;
    assign sticky = sticky_q;
    assign dz     = dz_q;
endmodule

// File: tb/tb_mant_div_seq.sv
// tb/tb_mant_div_seq.sv - self-checking bench for mant_div_seq against an arithmetic quotient model
module tb_mant_div_seq;
    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [23:0] a_man;
    logic [23:0] b_man;
    logic        busy;
    logic        done;
    logic [25:0] quo;
    logic        sticky;
    logic        dz;

    int compared   = 0;
    int mismatched = 0;

    mant_div_seq #(.MW(24), .QW(26)) dut (
        .clk    (clk),
        .rst    (rst),
        .start  (start),
        .a_man  (a_man),
        .b_man  (b_man),
        .busy   (busy),
        .done   (done),
        .quo    (quo),
        .sticky (sticky),
        .dz     (dz)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // Quotient is floor(a * 2^25 / b); sticky means a nonzero remainder.
    function automatic void model(input logic [23:0] a, input logic [23:0] b,
                                  output logic [25:0] q, output logic s);
        longint unsigned n;
        n = longint'(a) << 25;
        q = 26'(n / longint'(b));
        s = (n % longint'(b)) != 0;
    endfunction

    task automatic run_div(input string tag, input logic [23:0] a, input logic [23:0] b,
                           input bit ign);
        logic [25:0] eq;
        logic        es;
        logic        edz;
        int          elat;
        int          lat;
        int          busy_cnt;
        bit          got;
        if (b == 0) begin
            eq = '1; es = 1'b0; edz = 1'b1; elat = 2;
        end else begin
            model(a, b, eq, es); edz = 1'b0; elat = 27;
        end
        @(negedge clk);
        a_man = a; b_man = b; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        a_man = 24'($urandom); b_man = 24'($urandom);
        lat = 1; busy_cnt = 0; got = 0;
        while (lat <= 40 && !got) begin
            if (busy) busy_cnt++;
            if (done) got = 1;
            else begin
                if (ign && lat == 5) begin
                    start = 1'b1; a_man = 24'hFFFFFF; b_man = 24'h800001;
                end
                if (ign && lat == 6) start = 1'b0;
                @(negedge clk);
                lat++;
            end
        end
        check({tag, ".done_seen"}, 32'(got), 32'd1);
        check({tag, ".latency"}, 32'(lat), 32'(elat));
        check({tag, ".busy_cycles"}, 32'(busy_cnt), 32'(elat));
        check({tag, ".quo"}, 32'(quo), 32'(eq));
        check({tag, ".sticky"}, 32'(sticky), 32'(es));
        check({tag, ".dz"}, 32'(dz), 32'(edz));
        if (ign) begin
            start = 1'b1; a_man = 24'h800000; b_man = 24'hC00000;
        end
        @(negedge clk);
        start = 1'b0;
        check({tag, ".done_pulse_end"}, 32'(done), 32'd0);
        check({tag, ".idle_after"}, 32'(busy), 32'd0);
        check({tag, ".quo_hold"}, 32'(quo), 32'(eq));
    endtask

    initial begin
        int done_seen;
        rst = 1'b1; start = 1'b0; a_man = '0; b_man = '0;
        #1;
        check("reset.busy", 32'(busy), 32'd0);
        check("reset.done", 32'(done), 32'd0);
        check("reset.quo", 32'(quo), 32'd0);
        check("reset.sticky", 32'(sticky), 32'd0);
        check("reset.dz", 32'(dz), 32'd0);
        repeat (2) @(negedge clk);
        rst = 1'b0;

        run_div("one", 24'h800000, 24'h800000, 0);
        check("one.quo_const", 32'(quo), 32'h2000000);
        run_div("1p5", 24'hC00000, 24'h800000, 0);
        check("1p5.quo_const", 32'(quo), 32'h3000000);
        run_div("2_3", 24'h800000, 24'hC00000, 0);
        check("2_3.quo_const", 32'(quo), 32'h1555555);
        check("2_3.sticky_const", 32'(sticky), 32'd1);
        run_div("max", 24'hFFFFFF, 24'h800000, 0);
        check("max.quo_const", 32'(quo), 32'h3FFFFFC);
        run_div("zero_a", 24'h000000, 24'h800000, 0);
        run_div("dz", 24'h900000, 24'h000000, 0);
        run_div("after_dz", 24'hA00000, 24'hE00000, 0);
        run_div("ignore", 24'hB00000, 24'h900000, 1);

        for (int i = 0; i < 16; i++) begin
            logic [23:0] ra;
            logic [23:0] rb;
            ra = {1'b1, 23'($urandom)};
            rb = {1'b1, 23'($urandom)};
            if (i == 3) rb = ra;
            if (i == 4) rb = 24'hFFFFFF;
            run_div($sformatf("rand%0d", i), ra, rb, 0);
        end

        run_div("pre_rst", 24'h800000, 24'hC00000, 0);
        @(negedge clk);
        a_man = 24'hC00000; b_man = 24'h800000; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (9) @(negedge clk);
        #1 rst = 1'b1;
        #1;
        check("rst_mid.busy", 32'(busy), 32'd0);
        check("rst_mid.done", 32'(done), 32'd0);
        check("rst_mid.quo", 32'(quo), 32'd0);
        check("rst_mid.sticky", 32'(sticky), 32'd0);
        check("rst_mid.dz", 32'(dz), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        done_seen = 0;
        for (int i = 0; i < 35; i++) begin
            @(negedge clk);
            if (done || busy) done_seen++;
        end
        check("rst_mid.no_activity", 32'(done_seen), 32'd0);
        run_div("post_rst", 24'hC00000, 24'h800000, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end
endmodule
